// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared widths, enable constants, reset PC and fetch FSM encoding.
package if_fetch_pkg;
   localparam int InstAddrBus = 32;
   localparam int InstBus = 32;
   localparam int DataBus = 32;
   localparam logic Enable = 1'b1;
   localparam logic Disable = 1'b0;
   localparam logic [InstAddrBus-1:0] RESET_PC_DEFAULT = 32'h0;
   localparam logic [1:0] F_REQ = 2'd0;
   localparam logic [1:0] F_WAIT = 2'd1;
   localparam logic [1:0] F_DROP = 2'd2;
   localparam logic [1:0] F_HOLD = 2'd3;
   typedef struct packed {
      logic [InstBus-1:0] inst;
      logic [InstAddrBus-1:0] pc;
   } fetch_t;
endpackage

// File: rtl/if_fetch_skid_buf.sv
// if_skid_buf: one-entry {inst, pc, valid} buffer; clear beats load.
module if_skid_buf
   import if_fetch_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   en_i,
   input  logic                   load_i,
   input  logic                   unload_i,
   input  logic                   clear_i,
   input  logic [InstBus-1:0]     inst_i,
   input  logic [InstAddrBus-1:0] pc_i,
   output logic                   valid_o,
   output logic [InstBus-1:0]     inst_o,
   output logic [InstAddrBus-1:0] pc_o
);
   logic valid_q, valid_d;
   fetch_t ent_q, ent_d;
   always_comb begin
      valid_d = (clear_i || unload_i) ? Disable : load_i ? Enable : valid_q;
      ent_d = (load_i && !clear_i) ? fetch_t'({inst_i, pc_i}) : ent_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= Disable;
         ent_q <= '0;
      end else if (en_i) begin
         valid_q <= valid_d;
         ent_q <= ent_d;
      end
   end
   assign valid_o = valid_q;
   assign inst_o = ent_q.inst;
   assign pc_o = ent_q.pc;
endmodule

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch stage with one outstanding request, skid buffer
// and redirect flush that drains a stale in-flight response.
module if_fetch
   import if_fetch_pkg::*;
#(
   parameter logic [InstAddrBus-1:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   rdy,
   output logic                   if_re_o,
   output logic [InstAddrBus-1:0] if_addr_o,
   input  logic                   mc_busy_i,
   input  logic                   mc_done_i,
   input  logic [DataBus-1:0]     mc_data_i,
   input  logic                   mem_req_i,
   input  logic                   branch_i,
   input  logic [InstAddrBus-1:0] branch_target_i,
   input  logic                   stall_i,
   output logic                   valid_o,
   output logic [InstBus-1:0]     inst_o,
   output logic [InstAddrBus-1:0] pc_o
);
   logic [1:0] state_q, state_d;
   logic [InstAddrBus-1:0] pc_q, pc_d, opc_q, opc_d, skid_pc;
   logic [InstBus-1:0] inst_q, inst_d, skid_inst;
   logic valid_q, valid_d;
   logic skid_valid, skid_load, skid_unload, skid_clear;
   logic accept, slot_free;

   assign if_re_o = !rst && state_q == F_REQ && !skid_valid;
   assign accept = if_re_o && !mc_busy_i && !mem_req_i;
   assign slot_free = !valid_q || !stall_i;

   always_comb begin
      state_d = state_q;
      pc_d = pc_q;
      valid_d = valid_q && stall_i;
      inst_d = inst_q;
      opc_d = opc_q;
      skid_load = Disable;
      skid_unload = Disable;
      skid_clear = Disable;
      if (branch_i) begin
         pc_d = branch_target_i & ~32'h3;
         valid_d = Disable;
         skid_clear = Enable;
         // anything still owed by the controller must be drained first
         state_d = ((state_q == F_REQ && accept) ||
                    ((state_q == F_WAIT || state_q == F_DROP) && !mc_done_i)) ? F_DROP : F_REQ;
      end else begin
         case (state_q)
            F_REQ: state_d = accept ? F_WAIT : F_REQ;
            F_WAIT: if (mc_done_i) begin
               pc_d = pc_q + 32'd4;
               if (slot_free) begin
                  valid_d = Enable;
                  inst_d = mc_data_i;
                  opc_d = pc_q;
                  state_d = F_REQ;
               end else begin
                  skid_load = Enable;
                  state_d = F_HOLD;
               end
            end
            F_HOLD: if (slot_free) begin
               valid_d = Enable;
               inst_d = skid_inst;
               opc_d = skid_pc;
               skid_unload = Enable;
               state_d = F_REQ;
            end
            default: state_d = mc_done_i ? F_REQ : F_DROP;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= F_REQ;
         pc_q <= RESET_PC;
         valid_q <= Disable;
         inst_q <= '0;
         opc_q <= '0;
      end else if (rdy) begin
         state_q <= state_d;
         pc_q <= pc_d;
         valid_q <= valid_d;
         inst_q <= inst_d;
         opc_q <= opc_d;
      end
   end

   if_skid_buf u_skid (
      .clk      (clk),
      .rst      (rst),
      .en_i     (rdy),
      .load_i   (skid_load),
      .unload_i (skid_unload),
      .clear_i  (skid_clear),
      .inst_i   (mc_data_i),
      .pc_i     (pc_q),
      .valid_o  (skid_valid),
      .inst_o   (skid_inst),
      .pc_o     (skid_pc)
   );

   assign if_addr_o = pc_q;
   assign valid_o = valid_q;
   assign inst_o = inst_q;
   assign pc_o = opc_q;
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed scenarios plus randomized traffic against a
// memory-controller model and an in-order expected-instruction scoreboard.
module tb_if_fetch;
   logic clk = 0, rst, rdy, if_re_o, mc_busy_i, mc_done_i, mem_req_i, branch_i, stall_i, valid_o;
   logic [31:0] if_addr_o, mc_data_i, branch_target_i, inst_o, pc_o;
   int n_tests = 0, n_fail = 0, n_cons = 0;
   logic [31:0] exp_req;
   logic [31:0] pend[$];
   bit outst, rand_lat, rand_busy;
   int cnt, lat, n;
   logic [31:0] oaddr;

   if_fetch #(.RESET_PC(32'h0)) dut (
      .clk             (clk),
      .rst             (rst),
      .rdy             (rdy),
      .if_re_o         (if_re_o),
      .if_addr_o       (if_addr_o),
      .mc_busy_i       (mc_busy_i),
      .mc_done_i       (mc_done_i),
      .mc_data_i       (mc_data_i),
      .mem_req_i       (mem_req_i),
      .branch_i        (branch_i),
      .branch_target_i (branch_target_i),
      .stall_i         (stall_i),
      .valid_o         (valid_o),
      .inst_o          (inst_o),
      .pc_o            (pc_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5AC3C3;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One clock: capture pre-edge view, update the scoreboard, then let the
   // memory-controller model drive the next cycle's completion.
   task automatic step();
      logic acc, cons, br, rs;
      logic [31:0] a, tgt, cpc, cinst, e;
      rs = rst;
      acc = !rst && rdy && if_re_o && !mc_busy_i && !mem_req_i;
      br = rdy && branch_i;
      cons = rdy && valid_o && !stall_i && !branch_i;
      a = if_addr_o;
      tgt = branch_target_i;
      cpc = pc_o;
      cinst = inst_o;
      if (!rs && rdy) check("re_while_outstanding", {31'b0, if_re_o && outst}, 0);
      @(posedge clk);
      #1;
      if (rs) begin
         exp_req = 32'h0;
         pend.delete();
         outst = 0;
         cnt = 0;
      end else if (rdy) begin
         if (cons) begin
            n_cons++;
            if (pend.size() == 0) check("spurious_valid", 1, 0);
            else begin
               e = pend.pop_front();
               check("cons_pc", cpc, e);
               check("cons_inst", cinst, mem_word(e));
            end
         end
         if (acc) begin
            check("req_addr", a, exp_req);
            if (!br) pend.push_back(exp_req);
            exp_req = exp_req + 32'd4;
         end
         if (br) begin
            exp_req = tgt & ~32'h3;
            pend.delete();
         end
         check("valid_orphan", {31'b0, valid_o && pend.size() == 0}, 0);
      end
      @(negedge clk);
      mc_done_i = 0;
      if (acc) begin
         outst = 1;
         oaddr = a;
         cnt = rand_lat ? (($urandom % 2) ? 1 : int'($urandom_range(2, 9))) : lat;
      end
      if (outst) begin
         cnt--;
         if (cnt == 0) begin
            mc_done_i = 1;
            mc_data_i = mem_word(oaddr);
            outst = 0;
         end
      end
      if (!mc_done_i) mc_data_i = $urandom;
      mc_busy_i = outst || mc_done_i || (rand_busy && $urandom_range(0, 3) == 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst = 1; rdy = 1; stall_i = 0; branch_i = 0; branch_target_i = 0; mem_req_i = 0;
      mc_busy_i = 0; mc_done_i = 0; mc_data_i = 0; lat = 1; rand_lat = 0; rand_busy = 0;
      exp_req = 0; outst = 0; cnt = 0; oaddr = 0;
      @(negedge clk);
      step();
      step();
      check("rst_valid", valid_o, 0);
      check("rst_inst", inst_o, 0);
      check("rst_pc", pc_o, 0);
      check("rst_addr", if_addr_o, 0);
      check("rst_re", if_re_o, 0);
      rst = 0;
      #1;
      // hit stream: 0, 4, 8 with one bubble each
      for (int k = 0; k < 3; k++) begin
         check("hit_re", if_re_o, 1);
         check("hit_addr", if_addr_o, 4 * k);
         step();
         check("hit_bubble_re", if_re_o, 0);
         check("hit_bubble_valid", valid_o, 0);
         step();
         check("hit_valid", valid_o, 1);
         check("hit_pc", pc_o, 4 * k);
         check("hit_inst", inst_o, mem_word(4 * k));
      end
      // MEM priority holds the request
      mem_req_i = 1;
      for (int k = 0; k < 5; k++) begin
         step();
         check("memreq_re", if_re_o, 1);
         check("memreq_addr", if_addr_o, 12);
      end
      mem_req_i = 0;
      step();
      check("memreq_accept", if_re_o, 0);
      step();
      check("memreq_pc", pc_o, 12);
      // miss with stall over the done: response parks in the skid buffer
      lat = 8;
      stall_i = 1;
      check("skid_addr", if_addr_o, 32'h10);
      step();
      for (int k = 0; k < 8; k++) begin
         step();
         check("skid_stalled_pc", pc_o, 12);
      end
      check("skid_hold_re", if_re_o, 0);
      step();
      check("skid_hold_re2", if_re_o, 0);
      stall_i = 0;
      step();
      check("skid_valid", valid_o, 1);
      check("skid_pc", pc_o, 32'h10);
      check("skid_inst", inst_o, mem_word(32'h10));
      check("skid_next_re", if_re_o, 1);
      check("skid_next_addr", if_addr_o, 32'h14);
      // redirect three cycles into a miss: drain then fetch target
      step();
      step();
      step();
      branch_i = 1;
      branch_target_i = 32'h103;
      step();
      branch_i = 0;
      check("drop_valid", valid_o, 0);
      check("drop_re", if_re_o, 0);
      check("drop_addr", if_addr_o, 32'h100);
      n = 0;
      while (!if_re_o && n < 20) begin
         step();
         n++;
         check("drop_stale", valid_o, 0);
      end
      check("drop_drain_cycles", n, 5);
      check("drop_target_addr", if_addr_o, 32'h100);
      // redirect coincident with done
      lat = 1;
      step();
      check("bd_done", mc_done_i, 1);
      branch_i = 1;
      branch_target_i = 32'h200;
      step();
      branch_i = 0;
      check("bd_valid", valid_o, 0);
      check("bd_re", if_re_o, 1);
      check("bd_addr", if_addr_o, 32'h200);
      // redirect together with acceptance, to the top word, then wrap
      branch_i = 1;
      branch_target_i = 32'hFFFF_FFFF;
      step();
      branch_i = 0;
      n = 0;
      while (!if_re_o && n < 10) begin
         step();
         n++;
      end
      check("wrap_target", if_addr_o, 32'hFFFF_FFFC);
      step();
      step();
      check("wrap_pc", pc_o, 32'hFFFF_FFFC);
      check("wrap_next_addr", if_addr_o, 32'h0);
      // rdy low freezes everything, even a redirect
      stall_i = 1;
      mem_req_i = 1;
      step();
      rdy = 0;
      stall_i = 0;
      branch_i = 1;
      branch_target_i = 32'h300;
      for (int k = 0; k < 3; k++) begin
         step();
         check("rdy_valid", valid_o, 1);
         check("rdy_pc", pc_o, 32'hFFFF_FFFC);
         check("rdy_addr", if_addr_o, 32'h0);
      end
      branch_i = 0;
      rdy = 1;
      mem_req_i = 0;
      // reset in the middle of a miss
      lat = 8;
      step();
      check("rstw_wait_re", if_re_o, 0);
      step();
      rst = 1;
      step();
      check("rstw_valid", valid_o, 0);
      check("rstw_addr", if_addr_o, 32'h0);
      rst = 0;
      #1;
      check("rstw_re", if_re_o, 1);
      // randomized traffic
      rand_lat = 1;
      rand_busy = 1;
      n_cons = 0;
      for (int k = 0; k < 3000; k++) begin
         stall_i = $urandom_range(0, 2) == 0;
         mem_req_i = $urandom_range(0, 3) == 0;
         branch_i = $urandom_range(0, 19) == 0;
         branch_target_i = $urandom & 32'h0000_0FFF;
         step();
      end
      check("rand_progress", {31'b0, n_cons > 100}, 1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
